// File: rtl/frogger_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frogger_game_sequencer
// Brief    : Game controller issuing setFrogger commands and tracking lives,
//            level, pause, game-over and timed freezes after death or level-up.
// Revision : 1.0  initial release
// ============================================================================
module frogger_game_sequencer #(
    parameter int LIVES_INIT  = 3,
    parameter int LEVEL_MAX   = 15,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int HOLD_WIDTH  = 26
) (
    input  logic       SC_STATEMACHINEFROGGER_CLOCK_50,
    input  logic       SC_STATEMACHINEFROGGER_RESET_InHigh,
    input  logic       start_InLow,
    input  logic       pause_InLow,
    input  logic       collision_InLow,
    input  logic       reachedTop_InLow,
    output logic [1:0] setFrogger_Out,
    output logic [1:0] lives_Out,
    output logic [3:0] level_Out,
    output logic       gameOver_Out,
    output logic       levelUp_Out
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CLEAR    = 4'd1,
        ST_INIT     = 4'd2,
        ST_PLAY     = 4'd3,
        ST_PAUSE    = 4'd4,
        ST_HIT      = 4'd5,
        ST_LVLUP    = 4'd6,
        ST_HOLD     = 4'd7,
        ST_GAMEOVER = 4'd8
    } state_t;

    localparam logic [1:0] C_CMD_RUN    = 2'b00;
    localparam logic [1:0] C_CMD_FREEZE = 2'b01;
    localparam logic [1:0] C_CMD_INIT   = 2'b10;
    localparam logic [1:0] C_CMD_CLEAR  = 2'b11;

    localparam logic [1:0]            C_LIVES_INIT = 2'(LIVES_INIT);
    localparam logic [3:0]            C_LEVEL_MAX  = 4'(LEVEL_MAX);
    localparam logic [HOLD_WIDTH-1:0] C_HOLD_LAST  = HOLD_WIDTH'(HOLD_CYCLES - 1);

    state_t                state_q, state_d;
    logic [1:0]            lives_q, lives_d;
    logic [3:0]            level_q, level_d;
    logic [HOLD_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]            set_frogger_q, set_frogger_d;
    logic                  game_over_q, game_over_d;
    logic                  level_up_q, level_up_d;
    logic                  start_prev_q, pause_prev_q;
    logic                  start_e, pause_e;

    assign start_e = start_prev_q & ~start_InLow;
    assign pause_e = pause_prev_q & ~pause_InLow;

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_e) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                lives_d = C_LIVES_INIT;
                level_d = 4'd0;
                state_d = ST_INIT;
            end
            ST_INIT: begin
                hold_cnt_d = '0;
                state_d    = ST_PLAY;
            end
            ST_PLAY: begin
                if (!collision_InLow)       state_d = ST_HIT;
                else if (!reachedTop_InLow) state_d = ST_LVLUP;
                else if (pause_e)           state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (start_e)      state_d = ST_CLEAR;
                else if (pause_e) state_d = ST_PLAY;
            end
            ST_HIT: begin
                hold_cnt_d = '0;
                if (lives_q == 2'd1) begin
                    lives_d = 2'd0;
                    state_d = ST_GAMEOVER;
                end else begin
                    lives_d = lives_q - 2'd1;
                    state_d = ST_HOLD;
                end
            end
            ST_LVLUP: begin
                hold_cnt_d = '0;
                if (level_q < C_LEVEL_MAX) level_d = level_q + 4'd1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Counter runs 0..HOLD_CYCLES-1 so the freeze spans exactly HOLD_CYCLES cycles
                if (hold_cnt_q == C_HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = ST_INIT;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_GAMEOVER: begin
                if (start_e) state_d = ST_CLEAR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the next state so they are valid the cycle a state is entered
    always_comb begin
        set_frogger_d = C_CMD_FREEZE;
        case (state_d)
            ST_CLEAR: set_frogger_d = C_CMD_CLEAR;
            ST_INIT:  set_frogger_d = C_CMD_INIT;
            ST_PLAY:  set_frogger_d = C_CMD_RUN;
            default:  set_frogger_d = C_CMD_FREEZE;
        endcase
        game_over_d = (state_d == ST_GAMEOVER);
        level_up_d  = (state_d == ST_LVLUP);
    end

    always_ff @(posedge SC_STATEMACHINEFROGGER_CLOCK_50 or posedge SC_STATEMACHINEFROGGER_RESET_InHigh) begin
        if (SC_STATEMACHINEFROGGER_RESET_InHigh) begin
            state_q       <= ST_IDLE;
            lives_q       <= C_LIVES_INIT;
            level_q       <= 4'd0;
            hold_cnt_q    <= '0;
            set_frogger_q <= C_CMD_FREEZE;
            game_over_q   <= 1'b0;
            level_up_q    <= 1'b0;
            start_prev_q  <= 1'b1;
            pause_prev_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            hold_cnt_q    <= hold_cnt_d;
            set_frogger_q <= set_frogger_d;
            game_over_q   <= game_over_d;
            level_up_q    <= level_up_d;
            start_prev_q  <= start_InLow;
            pause_prev_q  <= pause_InLow;
        end
    end

    assign setFrogger_Out = set_frogger_q;
    assign lives_Out      = lives_q;
    assign level_Out      = level_q;
    assign gameOver_Out   = game_over_q;
    assign levelUp_Out    = level_up_q;

endmodule
`default_nettype wire

// File: tb/tb_frogger_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frogger_game_sequencer
// Brief    : Directed bench for frogger_game_sequencer with a short hold time.
// Revision : 1.0  initial release
// ============================================================================
module tb_frogger_game_sequencer;

    localparam int C_HOLD = 4;

    logic       clk;
    logic       rst;
    logic       start_n, pause_n, coll_n, top_n;
    logic [1:0] set_frogger;
    logic [1:0] lives;
    logic [3:0] level;
    logic       game_over;
    logic       level_up;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    frogger_game_sequencer #(
        .LIVES_INIT (3),
        .LEVEL_MAX  (15),
        .HOLD_CYCLES(C_HOLD),
        .HOLD_WIDTH (4)
    ) dut (
        .SC_STATEMACHINEFROGGER_CLOCK_50    (clk),
        .SC_STATEMACHINEFROGGER_RESET_InHigh(rst),
        .start_InLow                        (start_n),
        .pause_InLow                        (pause_n),
        .collision_InLow                    (coll_n),
        .reachedTop_InLow                   (top_n),
        .setFrogger_Out                     (set_frogger),
        .lives_Out                          (lives),
        .level_Out                          (level),
        .gameOver_Out                       (game_over),
        .levelUp_Out                        (level_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expects the full freeze after HIT/LVLUP, then INIT and PLAY
    task automatic hold_and_resume(input string tag);
        for (int i = 0; i < C_HOLD; i++) begin
            step();
            chk({tag, "_hold_sf"}, 8'(set_frogger), 8'h01);
            if (level_up) pulses++;
        end
        step();
        chk({tag, "_init_sf"}, 8'(set_frogger), 8'h02);
        step();
        chk({tag, "_play_sf"}, 8'(set_frogger), 8'h00);
    endtask

    initial begin
        rst = 1'b1; start_n = 1'b1; pause_n = 1'b1; coll_n = 1'b1; top_n = 1'b1;
        step(); step();
        chk("rst_sf",    8'(set_frogger), 8'h01);
        chk("rst_lives", 8'(lives),       8'h03);
        chk("rst_level", 8'(level),       8'h00);
        chk("rst_go",    8'(game_over),   8'h00);
        chk("rst_lu",    8'(level_up),    8'h00);
        rst = 1'b0;
        step();
        chk("idle_sf", 8'(set_frogger), 8'h01);

        // New game
        start_n = 1'b0; step();
        chk("start_clear", 8'(set_frogger), 8'h03);
        start_n = 1'b1; step();
        chk("start_init",  8'(set_frogger), 8'h02);
        chk("start_lives", 8'(lives),       8'h03);
        step();
        chk("start_play",  8'(set_frogger), 8'h00);
        chk("start_level", 8'(level),       8'h00);

        // Single collision
        coll_n = 1'b0; step();
        chk("hit1_sf", 8'(set_frogger), 8'h01);
        coll_n = 1'b1;
        hold_and_resume("hit1");
        chk("hit1_lives", 8'(lives), 8'h02);

        coll_n = 1'b0; step(); coll_n = 1'b1;
        chk("hit2_sf", 8'(set_frogger), 8'h01);
        hold_and_resume("hit2");
        chk("hit2_lives", 8'(lives), 8'h01);

        // Last life
        coll_n = 1'b0; step(); coll_n = 1'b1;
        chk("hit3_sf", 8'(set_frogger), 8'h01);
        step();
        chk("go_flag",  8'(game_over),   8'h01);
        chk("go_lives", 8'(lives),       8'h00);
        chk("go_sf",    8'(set_frogger), 8'h01);
        coll_n = 1'b0; step(); step(); coll_n = 1'b1;
        chk("go_stay", 8'(game_over), 8'h01);

        start_n = 1'b0; step();
        chk("restart_clear", 8'(set_frogger), 8'h03);
        chk("restart_go",    8'(game_over),   8'h00);
        start_n = 1'b1; step();
        chk("restart_lives", 8'(lives), 8'h03);
        chk("restart_level", 8'(level), 8'h00);
        step();
        chk("restart_play", 8'(set_frogger), 8'h00);

        // Collision beats reachedTop
        coll_n = 1'b0; top_n = 1'b0; step();
        coll_n = 1'b1; top_n = 1'b1;
        chk("both_lu", 8'(level_up),    8'h00);
        chk("both_sf", 8'(set_frogger), 8'h01);
        hold_and_resume("both");
        chk("both_level", 8'(level), 8'h00);
        chk("both_lives", 8'(lives), 8'h02);

        // Level saturation
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            top_n = 1'b0; step(); top_n = 1'b1;
            chk("lvl_pulse", 8'(level_up), 8'h01);
            if (level_up) pulses++;
            hold_and_resume("lvl");
            chk("lvl_value", 8'(level), (i + 1 > 15) ? 8'd15 : 8'(i + 1));
        end
        chk("lvl_pulse_count", 8'(pulses), 8'd16);

        // Held pause yields one entry
        pause_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_held", 8'(set_frogger), 8'h01);
        end
        pause_n = 1'b1; coll_n = 1'b0; step(); coll_n = 1'b1;
        chk("pause_ignore_coll", 8'(set_frogger), 8'h01);
        chk("pause_lives",       8'(lives),       8'h02);
        pause_n = 1'b0; step(); pause_n = 1'b1;
        chk("unpause", 8'(set_frogger), 8'h00);
        step();
        chk("unpause_stay", 8'(set_frogger), 8'h00);

        // Start wins over pause while paused
        pause_n = 1'b0; step(); pause_n = 1'b1;
        chk("pause2", 8'(set_frogger), 8'h01);
        step();
        start_n = 1'b0; pause_n = 1'b0; step(); start_n = 1'b1; pause_n = 1'b1;
        chk("pause_abandon", 8'(set_frogger), 8'h03);
        step(); step();
        chk("abandon_play",  8'(set_frogger), 8'h00);
        chk("abandon_lives", 8'(lives),       8'h03);
        chk("abandon_level", 8'(level),       8'h00);

        // Reset mid-hold
        coll_n = 1'b0; step(); coll_n = 1'b1;
        step(); step(); step();
        chk("midhold_cnt", 8'(dut.hold_cnt_q), 8'h02);
        rst = 1'b1; #1;
        chk("midrst_sf",    8'(set_frogger),     8'h01);
        chk("midrst_lives", 8'(lives),           8'h03);
        chk("midrst_cnt",   8'(dut.hold_cnt_q),  8'h00);
        step();
        rst = 1'b0; step(); step();
        chk("midrst_idle", 8'(set_frogger), 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
